// File: rtl/hilo_muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_pkg
// Brief   : Shared types and constants for the HI/LO multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // Default operand / HI / LO width.
  localparam int HILO_WIDTH = 32;

  // Operation codes presented by the EX stage.
  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } hilo_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } hilo_state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer_iter.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_iter_datapath
// Brief   : Operand/accumulator registers with a one-bit-per-cycle
//           shift-add multiply and restoring divide step, plus the final
//           sign correction of the result.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_iter_datapath
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             start_div,
  input  logic             start_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // a holds the multiplicand / divisor magnitude, q the multiplier being
  // consumed (mul) or the dividend turning into the quotient (div), and acc
  // the upper product half (mul) or the partial remainder (div).
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] acc;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [WIDTH-1:0] mag_rs;
  logic [WIDTH-1:0] mag_rt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_neg;

  // Magnitudes of the operands; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    mag_rs = (start_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
    mag_rt = (start_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;
  end

  // One iteration: right-shifting shift-add for mul, left-shifting
  // restoring subtract for div.
  always_comb begin
    mul_sum   = q[0] ? ({1'b0, acc} + {1'b0, a}) : {1'b0, acc};
    rem_shift = {acc, q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, a};
    acc_next  = acc;
    q_next    = q;
    if (is_div) begin
      // Bit WIDTH of the difference is the borrow: set means restore.
      if (!rem_diff[WIDTH]) begin
        acc_next = rem_diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_shift[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = mul_sum[WIDTH:1];
      q_next   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // Operand capture on start, one iteration per step.
  always_ff @(posedge clock) begin
    if (reset) begin
      a        <= '0;
      q        <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      a        <= mag_rt;
      q        <= mag_rs;
      acc      <= '0;
      is_div   <= start_div;
      neg_q    <= start_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
      neg_r    <= start_signed && rs[WIDTH-1];
      div_zero <= (rt == '0);
    end else if (step) begin
      acc <= acc_next;
      q   <= q_next;
    end
  end

  // Sign correction applied to the finished result.
  // With a zero divisor the quotient is left at all ones. The remainder
  // equals |rs| then, and restoring the sign of rs yields rs bit-exact.
  always_comb begin
    product     = {acc, q};
    product_neg = -product;
    if (is_div) begin
      res_lo = (neg_q && !div_zero) ? (~q + 1'b1) : q;
      res_hi = neg_r ? (~acc + 1'b1) : acc;
    end else begin
      res_hi = neg_q ? product_neg[2*WIDTH-1:WIDTH] : product[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? product_neg[WIDTH-1:0]       : product[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_sequencer
// Brief   : HI/LO register owner and sequencer for the iterative
//           multiply/divide unit beside the EX-stage ALU.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EX_Op_Valid,
  input  logic [3:0]       EX_Op,
  input  logic [WIDTH-1:0] EX_Rs,
  input  logic [WIDTH-1:0] EX_Rt,
  output logic             EX_ALU_Stall,
  output logic [WIDTH-1:0] EX_HiLo_Result,
  output logic             HiLo_Busy
);

  hilo_op_t    op;
  hilo_state_t state;
  hilo_state_t state_next;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  logic is_muldiv;
  logic is_div_op;
  logic is_signed_op;
  logic accept;
  logic start;
  logic step;
  logic write_res;

  assign op = hilo_op_t'(EX_Op);

  // Operation class decode.
  always_comb begin
    is_muldiv    = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    is_div_op    = (op == DIV)  || (op == DIVU);
    is_signed_op = (op == MULT) || (op == DIV);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, FIX exactly one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (EX_Op_Valid && is_muldiv) state_next = RUN;
      RUN:  if (counter == CNT_W'(1))     state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode. Every non-NONE op stalls while busy, so nothing
  // can be accepted in the FIX cycle and the HI/LO write never collides.
  always_comb begin
    EX_ALU_Stall = EX_Op_Valid && (op != NONE) && (state != IDLE);
    accept       = EX_Op_Valid && (state == IDLE);
    start        = accept && is_muldiv;
    step         = (state == RUN);
    write_res    = (state == FIX);
  end

  // Iteration counter: loaded with WIDTH at issue, counts down to 1 in RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
    end else if (start) begin
      counter <= CNT_W'(WIDTH);
    end else if (step) begin
      counter <= counter - CNT_W'(1);
    end
  end

  // Busy flag registered from the next state so it tracks state != IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      HiLo_Busy <= 1'b0;
    end else begin
      HiLo_Busy <= (state_next != IDLE);
    end
  end

  // HI/LO registers: written by FIX or by an accepted MTHI/MTLO.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (write_res) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept) begin
      if (op == MTHI) hi <= EX_Rs;
      if (op == MTLO) lo <= EX_Rs;
    end
  end

  // MFHI/MFLO read path, same cycle.
  always_comb begin
    case (op)
      MFHI:    EX_HiLo_Result = hi;
      MFLO:    EX_HiLo_Result = lo;
      default: EX_HiLo_Result = '0;
    endcase
  end

  muldiv_iter_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .step        (step),
    .start_div   (is_div_op),
    .start_signed(is_signed_op),
    .rs          (EX_Rs),
    .rt          (EX_Rt),
    .res_hi      (res_hi),
    .res_lo      (res_lo)
  );

endmodule
`default_nettype wire
